goe_nport: RTL and testbench

- Parametrised successor to the two-port generic output engine (goe).
- Takes the ebm packet stream (134-bit words) and steers each packet to one of NUM_PORTS output channels, using a port index carried in the head word.
- Drops whole packets when the target port FIFO is above threshold or the index is illegal; keeps per-port and discard counters for lcm readback.
- One-cycle registered forwarding path.

---
 rtl/goe_nport.sv | 199 +++++++++++++++++++
 tb/tb_goe_nport.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/goe_nport.sv
// goe_nport: generic output engine with NUM_PORTS output channels.
// Steers each ebm packet (134-bit words) to the channel named in its head word.
// A whole packet is dropped when its index is illegal or the target FIFO is too
// full at the head. Packet, per-port, discard and framing-error counters are
// kept for lcm readback. Forwarding is a single registered stage.
// Build option: define GOE_MCAST_EN to read the head field as a port bitmap and
// replicate the packet to every selected port that is below threshold.
module goe_nport #(
  parameter int         NUM_PORTS      = 4,
  parameter int         PORT_FIELD_LSB = 120,
  parameter int         PIDX_W         = 4,
  parameter logic [7:0] USEDW_THRESH   = 8'd200,
  parameter int         CNT_W          = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [133:0]               in_goe_data,
  input  logic                       in_goe_data_wr,
  input  logic                       in_goe_valid,
  input  logic                       in_goe_valid_wr,
  input  logic [NUM_PORTS*8-1:0]     pktout_usedw,
  output logic [NUM_PORTS*134-1:0]   pktout_data,
  output logic [NUM_PORTS-1:0]       pktout_data_wr,
  output logic [NUM_PORTS-1:0]       pktout_valid,
  output logic [NUM_PORTS-1:0]       pktout_valid_wr,
  output logic [CNT_W-1:0]           goe_pktin_cnt,
  output logic [NUM_PORTS*CNT_W-1:0] goe_portout_cnt,
  output logic [CNT_W-1:0]           goe_discard_cnt,
  output logic [CNT_W-1:0]           goe_err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state_q, state_d;
  logic [NUM_PORTS-1:0]   sel_q, sel_d;           // one-hot (or bitmap) of active ports
  logic [NUM_PORTS-1:0]   data_wr_q, data_wr_d;
  logic [NUM_PORTS-1:0]   valid_q, valid_d;
  logic [NUM_PORTS-1:0]   valid_wr_q, valid_wr_d;
  logic [133:0]           data_q [NUM_PORTS];
  logic [133:0]           data_d [NUM_PORTS];
  logic [CNT_W-1:0]       portout_q [NUM_PORTS];
  logic [CNT_W-1:0]       portout_d [NUM_PORTS];
  logic [CNT_W-1:0]       pktin_q, pktin_d;
  logic [CNT_W-1:0]       discard_q, discard_d;
  logic [CNT_W-1:0]       err_q, err_d;

  logic                   is_head, is_tail, vwr_err;
  logic [NUM_PORTS-1:0]   port_ok;
  logic [NUM_PORTS-1:0]   head_mask;
  logic                   take_head, frame_err, close_cnt;

  assign is_head = in_goe_data_wr && (in_goe_data[133:132] == 2'b01);
  assign is_tail = in_goe_data_wr && (in_goe_data[133:132] == 2'b10);
  // A valid strobe is only meaningful alongside the tail word.
  assign vwr_err = in_goe_valid_wr && !is_tail;

  // Per-port room check against the drop threshold.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_ok[p] = pktout_usedw[p*8 +: 8] < USEDW_THRESH;
    end
  end

`ifdef GOE_MCAST_EN
  // Head field is a port bitmap; full ports are masked for this packet only.
  always_comb begin
    head_mask = in_goe_data[PORT_FIELD_LSB +: NUM_PORTS] & port_ok;
  end
`else
  logic [PIDX_W-1:0] head_idx;
  assign head_idx = in_goe_data[PORT_FIELD_LSB +: PIDX_W];

  // Head field is a port index; an out-of-range index matches no port.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      head_mask[p] = (head_idx == PIDX_W'(p)) && port_ok[p];
    end
  end
`endif

  // Packet FSM next state, registered-output next values and counter updates.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned
    // (which would infer a latch).
    state_d    = state_q;
    sel_d      = sel_q;
    data_wr_d  = '0;
    valid_wr_d = '0;
    valid_d    = '0;
    data_d     = data_q;
    portout_d  = portout_q;
    pktin_d    = pktin_q;
    discard_d  = discard_q;
    take_head  = 1'b0;
    frame_err  = 1'b0;
    close_cnt  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_head)             take_head = 1'b1;
        else if (in_goe_data_wr) frame_err = 1'b1;   // stray body word
      end
      S_FWD: begin
        if (is_head) begin
          // Missing tail: close the old packet as bad, then take the new head.
          valid_wr_d = sel_q;
          frame_err  = 1'b1;
          take_head  = 1'b1;
        end else if (in_goe_data_wr) begin
          data_wr_d = sel_q;
          if (is_tail) begin
            if (in_goe_valid_wr) begin
              valid_wr_d = sel_q;
              valid_d    = sel_q & {NUM_PORTS{in_goe_valid}};
            end
            close_cnt = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (is_head) begin
          frame_err = 1'b1;
          take_head = 1'b1;
        end else if (is_tail) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_head) begin
      pktin_d = pktin_q + CNT_ONE;
      if (|head_mask) begin
        sel_d     = head_mask;
        data_wr_d = data_wr_d | head_mask;
        state_d   = S_FWD;
      end else begin
        sel_d     = '0;
        discard_d = discard_q + CNT_ONE;
        state_d   = S_DROP;
      end
    end

    for (int p = 0; p < NUM_PORTS; p++) begin
      if (data_wr_d[p])           data_d[p]    = in_goe_data;
      if (close_cnt && sel_q[p])  portout_d[p] = portout_q[p] + CNT_ONE;
    end

    err_d = err_q + CNT_W'(frame_err) + CNT_W'(vwr_err);
  end

  // State, registered outputs and counters; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      data_wr_q  <= '0;
      valid_q    <= '0;
      valid_wr_q <= '0;
      pktin_q    <= '0;
      discard_q  <= '0;
      err_q      <= '0;
      // NOTE: the per-port data registers are output state that must read 0 in
      // reset, so they are cleared like any other flop rather than left as RAM.
      for (int p = 0; p < NUM_PORTS; p++) begin
        data_q[p]    <= '0;
        portout_q[p] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      sel_q      <= sel_d;
      data_wr_q  <= data_wr_d;
      valid_q    <= valid_d;
      valid_wr_q <= valid_wr_d;
      pktin_q    <= pktin_d;
      discard_q  <= discard_d;
      err_q      <= err_d;
      data_q     <= data_d;
      portout_q  <= portout_d;
    end
  end

  assign pktout_data_wr  = data_wr_q;
  assign pktout_valid    = valid_q;
  assign pktout_valid_wr = valid_wr_q;
  assign goe_pktin_cnt   = pktin_q;
  assign goe_discard_cnt = discard_q;
  assign goe_err_cnt     = err_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_flat
    assign pktout_data[g*134 +: 134]       = data_q[g];
    assign goe_portout_cnt[g*CNT_W +: CNT_W] = portout_q[g];
  end

endmodule

// File: tb/tb_goe_nport.sv
// Scoreboard bench for goe_nport (NUM_PORTS=4): stimulus pushes expected port
// events, a negedge monitor pops and compares every strobe the DUT presents.
module tb_goe_nport;

  localparam int NP = 4;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [133:0]      in_goe_data;
  logic              in_goe_data_wr;
  logic              in_goe_valid;
  logic              in_goe_valid_wr;
  logic [NP*8-1:0]   pktout_usedw;
  logic [NP*134-1:0] pktout_data;
  logic [NP-1:0]     pktout_data_wr;
  logic [NP-1:0]     pktout_valid;
  logic [NP-1:0]     pktout_valid_wr;
  logic [CW-1:0]     goe_pktin_cnt;
  logic [NP*CW-1:0]  goe_portout_cnt;
  logic [CW-1:0]     goe_discard_cnt;
  logic [CW-1:0]     goe_err_cnt;

  goe_nport #(.NUM_PORTS(NP), .PORT_FIELD_LSB(120), .PIDX_W(4),
              .USEDW_THRESH(8'd200), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_goe_data(in_goe_data), .in_goe_data_wr(in_goe_data_wr),
    .in_goe_valid(in_goe_valid), .in_goe_valid_wr(in_goe_valid_wr),
    .pktout_usedw(pktout_usedw), .pktout_data(pktout_data),
    .pktout_data_wr(pktout_data_wr), .pktout_valid(pktout_valid),
    .pktout_valid_wr(pktout_valid_wr), .goe_pktin_cnt(goe_pktin_cnt),
    .goe_portout_cnt(goe_portout_cnt), .goe_discard_cnt(goe_discard_cnt),
    .goe_err_cnt(goe_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           port;
    logic         wr;
    logic [133:0] data;
    logic         vwr;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [1:0] T_HEAD = 2'b01, T_MID = 2'b11, T_TAIL = 2'b10;

  function automatic logic [133:0] mkw(input logic [1:0] t, input logic [3:0] f,
                                       input logic [31:0] tag);
    return {t, 4'h0, 4'h0, f, 88'h0, tag};
  endfunction

  function automatic void expect_ev(input int port, input logic wr,
                                    input logic [133:0] d, input logic vwr,
                                    input logic v);
    exp_t e;
    e.port = port; e.wr = wr; e.data = d; e.vwr = vwr; e.v = v;
    q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act,
                       input logic [CW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  function automatic logic [CW-1:0] pcnt(input int p);
    return goe_portout_cnt[p*CW +: CW];
  endfunction

  // Drive one input cycle; strobes drop back to 0 afterwards.
  task automatic send(input logic [133:0] d, input logic wr, input logic vwr,
                      input logic v);
    in_goe_data     = d;
    in_goe_data_wr  = wr;
    in_goe_valid_wr = vwr;
    in_goe_valid    = v;
    @(posedge clk);
    #1;
    in_goe_data_wr  = 1'b0;
    in_goe_valid_wr = 1'b0;
    in_goe_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int budget = 10;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: %0d expected events never appeared, want 0", name, q.size());
      q.delete();
    end
  endtask

  // Monitor: every strobe the DUT presents must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      if (pktout_data_wr[p] || pktout_valid_wr[p]) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected output: port %0d wr=%b vwr=%b, want nothing",
                   p, pktout_data_wr[p], pktout_valid_wr[p]);
        end else begin
          e = q.pop_front();
          if (e.port != p || e.wr !== pktout_data_wr[p] || e.vwr !== pktout_valid_wr[p] ||
              (e.wr && pktout_data[p*134 +: 134] !== e.data) ||
              (e.vwr && pktout_valid[p] !== e.v)) begin
            miscompares++;
            $display("FAIL port event: got port %0d wr=%b vwr=%b v=%b data=%h, want port %0d wr=%b vwr=%b v=%b data=%h",
                     p, pktout_data_wr[p], pktout_valid_wr[p], pktout_valid[p],
                     pktout_data[p*134 +: 134], e.port, e.wr, e.vwr, e.v, e.data);
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [133:0] w;
    rst_n = 1'b0;
    in_goe_data = '0; in_goe_data_wr = 1'b0;
    in_goe_valid = 1'b0; in_goe_valid_wr = 1'b0;
    pktout_usedw = '0;
    #23 rst_n = 1'b1;
    idle(1);

    // Reset state.
    check("reset strobes", CW'({pktout_data_wr, pktout_valid_wr, pktout_valid}), '0);
    check("reset data", CW'(|pktout_data), '0);
    check("reset pktin", goe_pktin_cnt, 0);
    check("reset err", goe_err_cnt, 0);

`ifdef GOE_MCAST_EN
    // Bitmap 1011 with port 3 full: ports 0 and 1 only, same cycle.
    pktout_usedw[31:24] = 8'd250;
    w = mkw(T_HEAD, 4'b1011, 32'h100);
    expect_ev(0, 1, w, 0, 0); expect_ev(1, 1, w, 0, 0);
    send(w, 1, 0, 0);
    w = mkw(T_TAIL, 4'h0, 32'h101);
    expect_ev(0, 1, w, 1, 1); expect_ev(1, 1, w, 1, 1);
    send(w, 1, 1, 1);
    idle(3); drain("mcast");
    check("mcast portout0", pcnt(0), 1);
    check("mcast portout1", pcnt(1), 1);
    check("mcast portout3", pcnt(3), 0);
    check("mcast discard", goe_discard_cnt, 0);
    // Empty bitmap drops the packet.
    send(mkw(T_HEAD, 4'b0000, 32'h102), 1, 0, 0);
    send(mkw(T_TAIL, 4'h0, 32'h103), 1, 1, 1);
    idle(3); drain("mcast zero");
    check("mcast zero discard", goe_discard_cnt, 1);
    check("mcast pktin", goe_pktin_cnt, 2);
`else
    // T1: three-word packet to port 2.
    w = mkw(T_HEAD, 4'd2, 32'h11); expect_ev(2, 1, w, 0, 0); send(w, 1, 0, 0);
    w = mkw(T_MID,  4'd0, 32'h12); expect_ev(2, 1, w, 0, 0); send(w, 1, 0, 0);
    w = mkw(T_TAIL, 4'd0, 32'h13); expect_ev(2, 1, w, 1, 1); send(w, 1, 1, 1);
    idle(3); drain("t1");
    check("t1 portout2", pcnt(2), 1);
    check("t1 pktin", goe_pktin_cnt, 1);
    check("t1 discard", goe_discard_cnt, 0);

    // T2: illegal index 5 dropped, then a normal packet proves return to IDLE.
    send(mkw(T_HEAD, 4'd5, 32'h21), 1, 0, 0);
    send(mkw(T_MID,  4'd0, 32'h22), 1, 0, 0);
    send(mkw(T_TAIL, 4'd0, 32'h23), 1, 1, 1);
    idle(2);
    check("t2 discard", goe_discard_cnt, 1);
    w = mkw(T_HEAD, 4'd0, 32'h24); expect_ev(0, 1, w, 0, 0); send(w, 1, 0, 0);
    w = mkw(T_TAIL, 4'd0, 32'h25); expect_ev(0, 1, w, 1, 1); send(w, 1, 1, 1);
    idle(3); drain("t2");
    check("t2 portout0", pcnt(0), 1);
    check("t2 err", goe_err_cnt, 0);

    // T3: threshold boundary on port 1; usedw rise mid-packet never truncates.
    pktout_usedw[15:8] = 8'd200;
    send(mkw(T_HEAD, 4'd1, 32'h31), 1, 0, 0);
    send(mkw(T_TAIL, 4'd0, 32'h32), 1, 1, 1);
    idle(2);
    check("t3 discard@200", goe_discard_cnt, 2);
    check("t3 portout1@200", pcnt(1), 0);
    pktout_usedw[15:8] = 8'd199;
    w = mkw(T_HEAD, 4'd1, 32'h33); expect_ev(1, 1, w, 0, 0); send(w, 1, 0, 0);
    pktout_usedw[15:8] = 8'd255;
    w = mkw(T_MID,  4'd0, 32'h34); expect_ev(1, 1, w, 0, 0); send(w, 1, 0, 0);
    w = mkw(T_TAIL, 4'd0, 32'h35); expect_ev(1, 1, w, 1, 1); send(w, 1, 1, 1);
    pktout_usedw[15:8] = 8'd0;
    idle(3); drain("t3");
    check("t3 portout1@199", pcnt(1), 1);
    check("t3 pktin", goe_pktin_cnt, 5);

    // T4: head while forwarding on the same port.
    w = mkw(T_HEAD, 4'd0, 32'h41); expect_ev(0, 1, w, 0, 0); send(w, 1, 0, 0);
    w = mkw(T_MID,  4'd0, 32'h42); expect_ev(0, 1, w, 0, 0); send(w, 1, 0, 0);
    w = mkw(T_HEAD, 4'd0, 32'h43); expect_ev(0, 1, w, 1, 0); send(w, 1, 0, 0);
    check("t4 err", goe_err_cnt, 1);
    check("t4 portout0 closed", pcnt(0), 1);
    w = mkw(T_TAIL, 4'd0, 32'h44); expect_ev(0, 1, w, 1, 1); send(w, 1, 1, 1);
    idle(2);
    check("t4 portout0", pcnt(0), 2);
    // Stray body word in IDLE, then a lone valid strobe.
    send(mkw(T_MID, 4'd0, 32'h45), 1, 0, 0);
    send('0, 0, 1, 1);
    idle(2);
    check("t4 err stray", goe_err_cnt, 3);
    // Tail with valid=0 is forwarded and counted.
    w = mkw(T_HEAD, 4'd1, 32'h46); expect_ev(1, 1, w, 0, 0); send(w, 1, 0, 0);
    w = mkw(T_TAIL, 4'd0, 32'h47); expect_ev(1, 1, w, 1, 0); send(w, 1, 1, 0);
    idle(3); drain("t4");
    check("t4 portout1 bad", pcnt(1), 2);
    check("t4 pktin", goe_pktin_cnt, 8);

    // T5: async reset in the middle of a port-3 packet.
    w = mkw(T_HEAD, 4'd3, 32'h51); expect_ev(3, 1, w, 0, 0); send(w, 1, 0, 0);
    w = mkw(T_MID,  4'd0, 32'h52); expect_ev(3, 1, w, 0, 0); send(w, 1, 0, 0);
    idle(1); drain("t5 pre");
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t5 rst data", CW'(|pktout_data), 0);
    check("t5 rst strobes", CW'({pktout_data_wr, pktout_valid_wr, pktout_valid}), 0);
    check("t5 rst pktin", goe_pktin_cnt, 0);
    check("t5 rst portout", pcnt(0) | pcnt(1) | pcnt(2) | pcnt(3), 0);
    check("t5 rst discard", goe_discard_cnt, 0);
    #10 rst_n = 1'b1;
    idle(1);
    // Remainder of the old packet is not resumed.
    send(mkw(T_MID,  4'd0, 32'h53), 1, 0, 0);
    send(mkw(T_TAIL, 4'd0, 32'h54), 1, 1, 1);
    w = mkw(T_HEAD, 4'd3, 32'h55); expect_ev(3, 1, w, 0, 0); send(w, 1, 0, 0);
    w = mkw(T_TAIL, 4'd0, 32'h56); expect_ev(3, 1, w, 1, 1); send(w, 1, 1, 1);
    idle(3); drain("t5");
    check("t5 portout3", pcnt(3), 1);
    check("t5 pktin", goe_pktin_cnt, 1);
    check("t5 err", goe_err_cnt, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
